lsu_mem_initiator: RTL and testbench



---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/lsu_mem_initiator.sv | 139 +++++++++++++
 tb/tb_lsu_mem_initiator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store initiator.
//   - request size encodings (SZ_B, SZ_H, SZ_W, SZ_X)
//   - FSM state enum (IDLE, RD, WR, RESP)
//   - lane-index helper constants for the 32-bit word
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;  // illegal encoding

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane handling.
//   size        in  2   effective access size (SZ_B/SZ_H/SZ_W)
//   is_unsigned in  1   zero-extend loads instead of sign-extend
//   addr_lo     in  2   byte offset inside the word
//   load_word   in  32  word read from memory (load extract source)
//   store_word  in  32  previously read word (read-modify-write source)
//   wdata       in  32  right-justified store data
//   load_data   out 32  extracted and extended load result
//   merge_data  out 32  word to write back to memory
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] load_word,
  input  logic [31:0] store_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    logic signed [31:0] s;
    s = $signed(b);
    return uns ? {24'd0, b} : s;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    logic signed [31:0] s;
    s = $signed(h);
    return uns ? {16'd0, h} : s;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lane ignores addr_lo[0], so an unaligned half (checks off)
  // lands in its aligned container.
  assign byte_sel = load_word[{addr_lo, 3'b000} +: BYTE_BITS];
  assign half_sel = load_word[{addr_lo[1], 4'b0000} +: HALF_BITS];

  always_comb begin
    load_data = load_word;
    case (size)
      SZ_B:    load_data = ext_byte(byte_sel, is_unsigned);
      SZ_H:    load_data = ext_half(half_sel, is_unsigned);
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    merge_data = store_word;
    case (size)
      SZ_B:    merge_data[{addr_lo, 3'b000} +: BYTE_BITS]     = wdata[7:0];
      SZ_H:    merge_data[{addr_lo[1], 4'b0000} +: HALF_BITS] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: one-at-a-time load/store initiator for a word-wide
// data memory. Sub-word stores are read-modify-write.
// Optional feature macro: LSU_ALIGN_CHECK_EN (misaligned/illegal-size
// detection; when undefined resp_err is 0 and size 11 acts as a word).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned  request attributes
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid                      one-cycle completion pulse
//   resp_rdata, resp_err            extended load data (0 for stores), error
//   mem_ren, mem_wen                memory read / write enables
//   mem_addr, mem_wdata             word address and write word (0 when idle)
//   mem_rdata                       combinational read word
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_e    state, state_nxt;
  logic          we_q, uns_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, word_q, rdata_q;
  logic [DW-1:0] load_data, merge_data;
  logic          accept, req_err;
  logic [1:0]    size_eff;

  assign accept = req_valid & req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;
  assign size_eff = req_size;
  assign req_err  = (req_size == SZ_X) ||
                    ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign resp_err = (state == RESP) & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= req_err;
  end
`else
  assign size_eff = (req_size == SZ_X) ? SZ_W : req_size;
  assign req_err  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                           state_nxt = RESP;
          else if (!req_we || size_eff != SZ_W)  state_nxt = RD;
          else                                   state_nxt = WR;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read word capture, and response data. resp_rdata only
  // changes on the edge that enters RESP, so it holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= size_eff;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_err) rdata_q <= '0;
      end
      if (state == RD) begin
        word_q <= mem_rdata;
        if (!we_q) rdata_q <= load_data;
      end
      if (state == WR) rdata_q <= '0;
    end
  end

  lsu_lane_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .load_word   (mem_rdata),
    .store_word  (word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // Memory-side outputs are decoded from registered state, so they are
  // stable across the whole RD/WR cycle and drop with async reset.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign mem_ren    = (state == RD);
  assign mem_wen    = (state == WR);
  assign mem_addr   = (state == RD || state == WR) ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_wdata  = (state == WR) ? merge_data : '0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_mem_initiator #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the falling edge of WR.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(negedge clk) if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ren;
    int          wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          gap;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int ren, input int wen, input logic [31:0] waddr,
                              input logic [31:0] wdata, input int gap);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.ren = ren; e.wen = wen;
    e.waddr = waddr; e.wdata = wdata; e.gap = gap; e.acc = 0;
    return e;
  endfunction

  // Drive a request at a falling edge, wait (bounded) for IDLE, and record
  // the accept cycle for the scoreboard.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input exp_t e, input bit hold, input bit push);
    int n;
    exp_t ee;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_total++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%08h", addr);
      req_valid = 1'b0;
      return;
    end
    ee = e;
    ee.acc = cyc;
    if (push) exp_q.push_back(ee);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Monitor: counts memory enables per transaction and checks each response.
  int ren_cnt = 0, wen_cnt = 0, last_resp = -1000;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ren_cnt = 0; wen_cnt = 0;
      end else begin
        if (mem_ren || mem_wen) chk("ren_wen_exclusive", {31'd0, mem_ren & mem_wen}, 32'd0);
        if (mem_ren) ren_cnt++;
        if (mem_wen) begin
          wen_cnt++;
          if (exp_q.size() > 0) begin
            chk("wr_addr", mem_addr, exp_q[0].waddr);
            chk("wr_data", mem_wdata, exp_q[0].wdata);
          end
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_resp: rdata 0x%08h err %0b with no request outstanding", resp_rdata, resp_err);
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("latency", cyc - e.acc, e.lat);
            chk("ren_cycles", ren_cnt, e.ren);
            chk("wen_cycles", wen_cnt, e.wen);
            if (e.gap != 0) chk("resp_gap", cyc - last_resp, e.gap);
          end
          last_resp = cyc;
          ren_cnt = 0; wen_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset: outputs idle, and a pending request is not accepted.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_en", {30'd0, mem_ren, mem_wen}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Preload and byte/half loads from word 0x8 = 0x80FF_7F01.
    issue(1, 2'b10, 0, 32'h8,  32'h80FF_7F01, mk(0, 0, 2, 0, 1, 32'h8, 32'h80FF_7F01, 0), 0, 1);
    issue(0, 2'b00, 0, 32'hA,  0, mk(32'hFFFF_FFFF, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b00, 1, 32'hA,  0, mk(32'h0000_00FF, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b01, 0, 32'hA,  0, mk(32'hFFFF_80FF, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b01, 1, 32'hA,  0, mk(32'h0000_80FF, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b00, 0, 32'h9,  0, mk(32'h0000_007F, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b01, 0, 32'h8,  0, mk(32'h0000_7F01, 0, 2, 1, 0, 0, 0, 0), 0, 1);

    // Word store then load back.
    issue(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, mk(0, 0, 2, 0, 1, 32'h10, 32'hDEAD_BEEF, 0), 0, 1);
    issue(0, 2'b10, 0, 32'h10, 0, mk(32'hDEAD_BEEF, 0, 2, 1, 0, 0, 0, 0), 0, 1);

    // Read-modify-write sub-word stores.
    issue(1, 2'b10, 0, 32'h10, 32'h1122_3344, mk(0, 0, 2, 0, 1, 32'h10, 32'h1122_3344, 0), 0, 1);
    issue(1, 2'b00, 0, 32'h11, 32'hFFFF_FFAB, mk(0, 0, 3, 1, 1, 32'h10, 32'h1122_AB44, 0), 0, 1);
    issue(1, 2'b01, 0, 32'h12, 32'h1234_CDEF, mk(0, 0, 3, 1, 1, 32'h10, 32'hCDEF_AB44, 0), 0, 1);
    issue(0, 2'b10, 0, 32'h10, 0, mk(32'hCDEF_AB44, 0, 2, 1, 0, 0, 0, 0), 0, 1);

`ifdef LSU_ALIGN_CHECK_EN
    issue(0, 2'b10, 0, 32'h13, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0, 1);
    issue(1, 2'b01, 0, 32'h11, 32'h5555, mk(0, 1, 1, 0, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b11, 0, 32'h10, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0, 1);
`else
    issue(0, 2'b10, 0, 32'h13, 0, mk(32'hCDEF_AB44, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b01, 0, 32'h11, 0, mk(32'hFFFF_AB44, 0, 2, 1, 0, 0, 0, 0), 0, 1);
    issue(0, 2'b11, 0, 32'h10, 0, mk(32'hCDEF_AB44, 0, 2, 1, 0, 0, 0, 0), 0, 1);
`endif

    // Reset during the RD cycle of a byte store: nothing completes.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    issue(1, 2'b00, 0, 32'h9, 32'h55, mk(0, 0, 3, 1, 1, 32'h8, 32'h80FF_5501, 0), 0, 0);
    chk("abort_ren_before", {31'd0, mem_ren}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ren_drop", {31'd0, mem_ren}, 32'd0);
    chk("abort_wen", {31'd0, mem_wen}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("abort_no_write", mem[2], 32'h80FF_7F01);
    rst_n = 1'b1;
    #1 chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    issue(0, 2'b10, 0, 32'h8, 0, mk(32'h80FF_7F01, 0, 2, 1, 0, 0, 0, 0), 0, 1);

    // Back-to-back loads with req_valid held high.
    issue(0, 2'b00, 0, 32'hA,  0, mk(32'hFFFF_FFFF, 0, 2, 1, 0, 0, 0, 0), 1, 1);
    issue(0, 2'b01, 1, 32'h8,  0, mk(32'h0000_7F01, 0, 2, 1, 0, 0, 0, 3), 1, 1);
    issue(0, 2'b10, 0, 32'h10, 0, mk(32'hCDEF_AB44, 0, 2, 1, 0, 0, 0, 3), 0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL resp_timeout: %0d responses never arrived", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
